// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: instruction funct codes and FSM states.
package hilo_muldiv_pkg;

    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, funct, a, b, flush, input stall, done, hi, lo);
    modport slave  (input start, funct, a, b, flush, output stall, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Iterative unsigned restoring divider, one quotient bit per clock; quotient/remainder expose
// the result of the iteration in progress so the caller can commit it on the final edge.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    count;
    logic             busy;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Bit WIDTH of diff is the borrow: set means the trial subtraction must be undone.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvsr_q};
    assign remainder = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quotient  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign valid     = busy & (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
            count  <= '0;
            busy   <= 1'b1;
        end else if (abort) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (busy) begin
            rem_q <= remainder;
            quo_q <= quotient;
            count <= count + 1'b1;
            if (valid)
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register file with multi-cycle MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO;
// stalls the pipeline until a multiply or divide result is committed.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    hilo_muldiv_if.slave  bus
);
    state_t state, state_next;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic               q_neg, r_neg, div_zero;
    logic [WIDTH-1:0]   raw_a;
    logic               accept, is_mul, is_div, div_signed;
    logic [WIDTH-1:0]   div_dividend, div_divisor, div_q, div_r;
    logic               div_valid, stall_c;

    assign accept     = bus.start & ~bus.flush & (state == S_IDLE);
    assign is_mul     = (bus.funct == EXE_MULT) | (bus.funct == EXE_MULTU);
    assign is_div     = (bus.funct == EXE_DIV)  | (bus.funct == EXE_DIVU);
    assign div_signed = (bus.funct == EXE_DIV);

    assign div_dividend = (div_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign div_divisor  = (div_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    assign ext_a   = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
    assign ext_b   = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
    assign product = ext_a * ext_b;

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept & is_div),
        .abort     (bus.flush & (state == S_DIV)),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_q),
        .remainder (div_r),
        .valid     (div_valid)
    );

    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept & is_mul) begin
                    state_next = S_MUL;
                    stall_c    = 1'b1;
                end else if (accept & is_div) begin
                    state_next = S_DIV;
                    stall_c    = 1'b1;
                end
            end
            S_MUL: begin
                stall_c    = ~bus.flush;
                state_next = bus.flush ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                stall_c = ~bus.flush;
                if (bus.flush)
                    state_next = S_IDLE;
                else if (div_valid)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.stall = stall_c & resetn;
    assign bus.done  = (state == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_zero   <= 1'b0;
            raw_a      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                case (bus.funct)
                    EXE_MTHI: hi_q <= bus.a;
                    EXE_MTLO: lo_q <= bus.a;
                    EXE_MULT, EXE_MULTU: begin
                        mul_a      <= bus.a;
                        mul_b      <= bus.b;
                        mul_signed <= (bus.funct == EXE_MULT);
                    end
                    EXE_DIV, EXE_DIVU: begin
                        q_neg    <= div_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg    <= div_signed & bus.a[WIDTH-1];
                        div_zero <= (bus.b == '0);
                        raw_a    <= bus.a;
                    end
                    default: ;
                endcase
            end
            if ((state == S_MUL) && !bus.flush)
                {hi_q, lo_q} <= product;
            // Divide by zero bypasses sign fixup and reports the raw dividend in HI.
            if ((state == S_DIV) && !bus.flush && div_valid) begin
                if (div_zero) begin
                    lo_q <= '1;
                    hi_q <= raw_a;
                end else begin
                    lo_q <= q_neg ? -div_q : div_q;
                    hi_q <= r_neg ? -div_r : div_r;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: scoreboard of expected HI/LO/stall counts checked on each done pulse.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    localparam int W = 32;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(W)) bus();

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written from architectural semantics, not from the datapath.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        h = '0;
        l = '0;
        case (f)
            EXE_MULT: begin
                p = 64'($signed(a)) * 64'($signed(b));
                {h, l} = p;
            end
            EXE_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {h, l} = p;
            end
            EXE_DIV: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'h0;
                end else begin
                    l = $signed(a) / $signed(b);
                    h = $signed(a) % $signed(b);
                end
            end
            EXE_DIVU: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                                 input string tag);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct = f;
        bus.a     = av;
        bus.b     = bv;
        model(f, av, bv, e.hi, e.lo);
        e.tag    = tag;
        e.stalls = (f == EXE_MULT || f == EXE_MULTU) ? 2 : 33;
        sb.push_back(e);
    endtask

    // hold keeps start asserted through DONE to prove it does not retrigger.
    task automatic checkOutput(input bit hold);
        exp_t e;
        int   stalls = 0;
        bit   seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.stall === 1'b1) stalls++;
                @(negedge clk);
                if (!hold) bus.start = 1'b0;
            end
        end
        e = sb.pop_front();
        check({e.tag, " done"}, 64'(seen), 64'd1);
        check({e.tag, " stall cycles"}, 64'(stalls), 64'(e.stalls));
        check({e.tag, " stall in DONE"}, 64'(bus.stall), 64'd0);
        check({e.tag, " hi"}, 64'(bus.hi), 64'(e.hi));
        check({e.tag, " lo"}, 64'(bus.lo), 64'(e.lo));
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check({e.tag, " done pulse width"}, 64'(bus.done), 64'd0);
        check({e.tag, " no retrigger"}, 64'(bus.stall), 64'd0);
    endtask

    initial begin
        int done_seen;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        #1;
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        check("reset stall", 64'(bus.stall), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus(EXE_MULT, 32'hFFFF_FFFF, 32'd2, "mult -1*2");
        checkOutput(1'b0);
        applyStimulus(EXE_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
        checkOutput(1'b0);
        applyStimulus(EXE_DIVU, 32'd100, 32'd7, "divu 100/7 held");
        checkOutput(1'b1);
        applyStimulus(EXE_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        checkOutput(1'b0);
        applyStimulus(EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        checkOutput(1'b0);
        applyStimulus(EXE_DIVU, 32'h0000_1234, 32'd0, "divu by zero");
        checkOutput(1'b0);
        applyStimulus(EXE_DIV, 32'hFFFF_FF9C, 32'd0, "div neg by zero");
        checkOutput(1'b0);
        applyStimulus(EXE_DIV, 32'd100, 32'hFFFF_FFF9, "div 100/-7");
        checkOutput(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? EXE_MULT : EXE_DIV, $urandom, $urandom_range(1, 32'hFFFF),
                          $sformatf("random op %0d", i));
            checkOutput(1'b0);
        end

        @(negedge clk);
        bus.start = 1'b1; bus.funct = EXE_MTHI; bus.a = 32'hDEAD_BEEF;
        #1 check("mthi stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.funct = EXE_MTLO; bus.a = 32'd5;
        #1 check("mtlo stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("mthi hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        check("mtlo lo", 64'(bus.lo), 64'd5);
        check("mthi/mtlo done", 64'(bus.done), 64'd0);

        @(negedge clk);
        bus.start = 1'b1; bus.funct = EXE_MTHI; bus.a = 32'h11;
        @(negedge clk);
        bus.funct = EXE_MTLO; bus.a = 32'h22;
        @(negedge clk);
        bus.funct = EXE_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1 check("flush stall low", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.done === 1'b1 || bus.stall === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("flush no done/stall after abort", 64'(done_seen), 64'd0);
        check("flush hi kept", 64'(bus.hi), 64'h11);
        check("flush lo kept", 64'(bus.lo), 64'h22);

        @(negedge clk);
        bus.start = 1'b1; bus.funct = EXE_MULT; bus.a = 32'd7; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        #1 check("stall in MUL", 64'(bus.stall), 64'd1);
        resetn = 1'b0;
        #1;
        check("async reset hi", 64'(bus.hi), 64'd0);
        check("async reset lo", 64'(bus.lo), 64'd0);
        check("async reset stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        #1 check("async reset done", 64'(bus.done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(EXE_MULTU, 32'd3, 32'd4, "multu 3*4 after reset");
        checkOutput(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
